// File: rtl/plusarg_watchdog.sv
// Cycle watchdog armed from a plusarg-supplied limit: counts prescaled ticks while
// enabled, restarts on kick, and latches an expiry until it is cleared.
module plusarg_watchdog #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             kick,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             timeout,
    output logic             expire_pulse,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUNNING  = 2'd1,
        EXPIRED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             expire_q, expire_d;
    logic             tick;
    logic             pre_clr;

    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] pre_q;

            assign tick = (pre_q == PW'(PRESCALE - 1));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pre_q <= '0;
                end else if (pre_clr) begin
                    pre_q <= '0;
                end else if (tick) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end
        end else begin : g_no_prescale
            logic unused_pre_clr;
            assign unused_pre_clr = pre_clr;
            assign tick           = 1'b1;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DISABLED;
            count_q  <= '0;
            limit_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            expire_q <= expire_d;
        end
    end

    // Priority inside RUNNING: disable, then kick, then the tick/expiry path.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        expire_d = 1'b0;
        pre_clr  = 1'b0;
        case (state_q)
            DISABLED: begin
                count_d = '0;
                pre_clr = 1'b1;
                if (enable && (limit != '0)) begin
                    limit_d = limit;
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (!enable) begin
                    state_d = DISABLED;
                    count_d = '0;
                    pre_clr = 1'b1;
                end else if (kick) begin
                    count_d = '0;
                    pre_clr = 1'b1;
                end else if (tick) begin
                    // limit_q is nonzero here, so limit_q-1 never underflows
                    if (count_q == (limit_q - WIDTH'(1))) begin
                        state_d  = EXPIRED;
                        count_d  = limit_q;
                        expire_d = 1'b1;
                        pre_clr  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
            EXPIRED: begin
                count_d = limit_q;
                pre_clr = 1'b1;
                if (clear) begin
                    state_d = DISABLED;
                    count_d = '0;
                end
            end
            default: begin
                state_d = DISABLED;
                count_d = '0;
                pre_clr = 1'b1;
            end
        endcase
    end

    assign count        = count_q;
    assign timeout      = (state_q == EXPIRED);
    assign expire_pulse = expire_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Directed bench for plusarg_watchdog: a PRESCALE=1 instance and a PRESCALE=4 instance
// driven through arming, kick, disable, limit-change, expiry/clear and async reset.
module tb_plusarg_watchdog;

    localparam logic [1:0] S_DIS = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_EXP = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] limit  = '0;
    logic        enable = 1'b0;
    logic        kick   = 1'b0;
    logic        clear  = 1'b0;
    logic [31:0] count;
    logic        timeout;
    logic        expire_pulse;
    logic [1:0]  state_dbg;

    logic [7:0]  limit4  = '0;
    logic        enable4 = 1'b0;
    logic        kick4   = 1'b0;
    logic        clear4  = 1'b0;
    logic [7:0]  count4;
    logic        timeout4;
    logic        expire_pulse4;
    logic [1:0]  state_dbg4;

    int n_assert = 0;
    int n_fail   = 0;

    plusarg_watchdog #(.WIDTH(32), .PRESCALE(1)) dut (
        .clock(clock), .reset(reset), .limit(limit), .enable(enable),
        .kick(kick), .clear(clear), .count(count), .timeout(timeout),
        .expire_pulse(expire_pulse), .state_dbg(state_dbg)
    );

    plusarg_watchdog #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clock(clock), .reset(reset), .limit(limit4), .enable(enable4),
        .kick(kick4), .clear(clear4), .count(count4), .timeout(timeout4),
        .expire_pulse(expire_pulse4), .state_dbg(state_dbg4)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] c, input logic t,
                       input logic p, input logic [1:0] s);
        check({tag, ".count"}, count, c);
        check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
        check({tag, ".pulse"}, {31'd0, expire_pulse}, {31'd0, p});
        check({tag, ".state"}, {30'd0, state_dbg}, {30'd0, s});
    endtask

    task automatic chk4(input string tag, input logic [7:0] c, input logic t,
                        input logic p, input logic [1:0] s);
        check({tag, ".count"}, {24'd0, count4}, {24'd0, c});
        check({tag, ".timeout"}, {31'd0, timeout4}, {31'd0, t});
        check({tag, ".pulse"}, {31'd0, expire_pulse4}, {31'd0, p});
        check({tag, ".state"}, {30'd0, state_dbg4}, {30'd0, s});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("reset", 32'd0, 1'b0, 1'b0, S_DIS);
        chk4("reset4", 8'd0, 1'b0, 1'b0, S_DIS);
        #2 reset = 1'b0;

        // basic arming and expiry at limit 3
        limit = 32'd3; enable = 1'b1;
        step(); chk("l3_e1", 32'd0, 1'b0, 1'b0, S_RUN);
        step(); chk("l3_e2", 32'd1, 1'b0, 1'b0, S_RUN);
        step(); chk("l3_e3", 32'd2, 1'b0, 1'b0, S_RUN);
        step(); chk("l3_e4", 32'd3, 1'b1, 1'b1, S_EXP);
        step(); chk("l3_e5", 32'd3, 1'b1, 1'b0, S_EXP);
        kick = 1'b1; enable = 1'b0;
        step(); chk("exp_ignores_kick_enable", 32'd3, 1'b1, 1'b0, S_EXP);
        kick = 1'b0; clear = 1'b1;
        step(); chk("exp_clear", 32'd0, 1'b0, 1'b0, S_DIS);
        clear = 1'b0;

        // kick on the terminal cycle wins over expiry
        limit = 32'd5; enable = 1'b1;
        step(); chk("l5_arm", 32'd0, 1'b0, 1'b0, S_RUN);
        for (int i = 1; i <= 4; i++) begin
            step(); chk("l5_count", i, 1'b0, 1'b0, S_RUN);
        end
        kick = 1'b1;
        step(); chk("l5_kick_terminal", 32'd0, 1'b0, 1'b0, S_RUN);
        kick = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(); chk("l5_recount", i, 1'b0, 1'b0, S_RUN);
        end
        step(); chk("l5_expire", 32'd5, 1'b1, 1'b1, S_EXP);
        clear = 1'b1; enable = 1'b0;
        step(); chk("l5_clear", 32'd0, 1'b0, 1'b0, S_DIS);
        clear = 1'b0;

        // disable beats kick and terminal tick
        limit = 32'd2; enable = 1'b1;
        step(); chk("dis_arm", 32'd0, 1'b0, 1'b0, S_RUN);
        step(); chk("dis_c1", 32'd1, 1'b0, 1'b0, S_RUN);
        enable = 1'b0; kick = 1'b1;
        step(); chk("dis_priority", 32'd0, 1'b0, 1'b0, S_DIS);
        kick = 1'b0;

        // limit 0 keeps the watchdog off
        limit = 32'd0; enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("lim0.state", {30'd0, state_dbg}, {30'd0, S_DIS});
            check("lim0.count", count, 32'd0);
        end

        // limit changes while running are ignored; re-arm samples the new limit
        limit = 32'd10;
        step(); chk("l10_arm", 32'd0, 1'b0, 1'b0, S_RUN);
        limit = 32'd2;
        for (int i = 1; i <= 9; i++) begin
            step(); chk("l10_count", i, 1'b0, 1'b0, S_RUN);
        end
        step(); chk("l10_expire", 32'd10, 1'b1, 1'b1, S_EXP);
        clear = 1'b1;
        step(); chk("l10_clear", 32'd0, 1'b0, 1'b0, S_DIS);
        clear = 1'b0;
        step(); chk("rearm_l2", 32'd0, 1'b0, 1'b0, S_RUN);
        step(); chk("rearm_c1", 32'd1, 1'b0, 1'b0, S_RUN);
        step(); chk("rearm_expire", 32'd2, 1'b1, 1'b1, S_EXP);

        // asynchronous reset between edges while expired
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'd0, 1'b0, 1'b0, S_DIS);
        #2 reset = 1'b0;
        step(); chk("post_reset_arm", 32'd0, 1'b0, 1'b0, S_RUN);
        enable = 1'b0;
        step(); chk("post_reset_dis", 32'd0, 1'b0, 1'b0, S_DIS);

        // PRESCALE=4, limit 2
        limit4 = 8'd2; enable4 = 1'b1;
        step(); chk4("p4_arm", 8'd0, 1'b0, 1'b0, S_RUN);
        for (int i = 0; i < 3; i++) begin
            step(); chk4("p4_pre0", 8'd0, 1'b0, 1'b0, S_RUN);
        end
        step(); chk4("p4_tick1", 8'd1, 1'b0, 1'b0, S_RUN);
        for (int i = 0; i < 3; i++) begin
            step(); chk4("p4_pre1", 8'd1, 1'b0, 1'b0, S_RUN);
        end
        step(); chk4("p4_expire", 8'd2, 1'b1, 1'b1, S_EXP);
        step(); chk4("p4_hold", 8'd2, 1'b1, 1'b0, S_EXP);
        clear4 = 1'b1; enable4 = 1'b0;
        step(); chk4("p4_clear", 8'd0, 1'b0, 1'b0, S_DIS);
        clear4 = 1'b0;

        // PRESCALE=4: kick mid-period restarts the prescaler too
        limit4 = 8'd3; enable4 = 1'b1;
        step(); chk4("p4k_arm", 8'd0, 1'b0, 1'b0, S_RUN);
        step(); step();
        kick4 = 1'b1;
        step(); chk4("p4k_kick", 8'd0, 1'b0, 1'b0, S_RUN);
        kick4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk4("p4k_pre0", 8'd0, 1'b0, 1'b0, S_RUN);
        end
        step(); chk4("p4k_tick1", 8'd1, 1'b0, 1'b0, S_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/plusarg_watchdog.md
PLUSARG_WATCHDOG -- requirements
Module: plusarg_watchdog

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the width of the limit and the cycle counter.
REQ-002 SHALL have parameter PRESCALE, default 1, the number of clock cycles per tick; legal range is 1 or greater.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port limit, input, WIDTH bits: timeout threshold in ticks, driven by the plusarg reader output; 0 means watchdog off.
REQ-006 SHALL have port enable, input, 1 bit: arms the watchdog while high.
REQ-007 SHALL have port kick, input, 1 bit: heartbeat that restarts the count.
REQ-008 SHALL have port clear, input, 1 bit: acknowledges an expiry.
REQ-009 SHALL have port count, output, WIDTH bits: the current tick count.
REQ-010 SHALL have port timeout, output, 1 bit: high while in state EXPIRED.
REQ-011 SHALL have port expire_pulse, output, 1 bit: a one-cycle strobe on entry to EXPIRED.

Function
REQ-012 SHALL implement three states: DISABLED, RUNNING and EXPIRED.
REQ-013 SHALL, in DISABLED with enable=1 and limit!=0, load limit into limit_q, clear count and prescaler, and go to RUNNING on the next edge.
REQ-014 SHALL stay in DISABLED when enable=0 or limit=0; count holds 0.
REQ-015 SHALL ignore changes to limit outside DISABLED; only limit_q governs expiry.
REQ-016 SHALL, in RUNNING, advance the prescaler every cycle and produce a tick when the prescaler equals PRESCALE-1, wrapping the prescaler to 0.
REQ-017 SHALL, when PRESCALE=1, tick every RUNNING cycle with no prescaler register.
REQ-018 SHALL, on each tick in RUNNING, set count to count+1; when count+1 equals limit_q, go to EXPIRED and assert expire_pulse for exactly that transition edge.
REQ-019 SHALL, when kick=1 in RUNNING, clear count and prescaler; kick takes priority over a simultaneous terminal tick, so no expiry occurs.
REQ-020 SHALL, when enable=0 in RUNNING, return to DISABLED with count and prescaler cleared; disable takes priority over kick and terminal tick.
REQ-021 SHALL, in EXPIRED, hold count at limit_q and ignore kick and enable.
REQ-022 SHALL, in EXPIRED with clear=1, clear count and go to DISABLED; re-arming then follows REQ-013.
REQ-023 SHALL never wrap count: expiry occurs at limit_q, which is at most 2^WIDTH-1.
REQ-024 SHALL never hold timeout and expire_pulse in conflicting states; expire_pulse=1 implies timeout=1 on the same cycle.
REQ-025 SHALL be fully synthesizable, with no simulation-only constructs.

Reset
REQ-026 SHALL, while reset=1, asynchronously force state=DISABLED, count=0, prescaler=0, limit_q=0, timeout=0 and expire_pulse=0.
REQ-027 SHALL, on reset asserted mid-RUNNING or in EXPIRED, immediately drop timeout and count to 0 without waiting for a clock edge.
REQ-028 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-029 SHALL be covered by this scenario: PRESCALE=1, limit=3, enable held high from cycle 0 -> RUNNING at edge 1; count reads 1,2 then timeout=1 with expire_pulse=1 on edge 4 only.
REQ-030 SHALL be covered by this scenario: PRESCALE=4, limit=2, enable high -> count reaches 1 after 4 RUNNING cycles; timeout asserts after 8 RUNNING cycles.
REQ-031 SHALL be covered by this scenario: limit=5, kick pulsed on the cycle count would reach 5 -> count=0, timeout stays 0; with no further kicks, expiry occurs 5 ticks later.
REQ-032 SHALL be covered by this scenario: limit=0 with enable=1 for 100 cycles -> state remains DISABLED and count=0 throughout.
REQ-033 SHALL be covered by this scenario: in RUNNING with limit_q=10, limit changed to 2 -> expiry still occurs at count 10; then clear=1 -> DISABLED, and re-arm samples 2.
REQ-034 SHALL be covered by this scenario: in EXPIRED, reset asserted between clock edges -> timeout=0 and count=0 before the next edge.
